wb_master_if: RTL



---
 rtl/wb_master_pkg.sv | 34 +++
 rtl/wb_bus_t.sv | 29 ++
 rtl/wb_lane_align.sv | 52 +++++
 rtl/wb_master_if.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/wb_master_pkg.sv
// ============================================================================
// wb_master_pkg : shared types and helpers for the Wishbone classic master.
// Revision      : 1.0
// ============================================================================
`default_nettype none

package wb_master_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = off[0];
      SZ_WORD: mis = (off != 2'b00);
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_bus_t.sv
// ============================================================================
// wb_bus_t : Wishbone classic bus bundle (32-bit data, byte selects).
// Revision : 1.0
// ============================================================================
`default_nettype none

interface wb_bus_t;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [31:0] wb_adr;
  logic [31:0] wb_dat_ms;
  logic [31:0] wb_dat_sm;
  logic [3:0]  sel;
  logic        wb_ack;
  logic        wb_err;

  modport master (
    output wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_ms, sel,
    input  wb_dat_sm, wb_ack, wb_err
  );

  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_ms, sel,
    output wb_dat_sm, wb_ack, wb_err
  );
endinterface

`default_nettype wire

// File: rtl/wb_lane_align.sv
// ============================================================================
// wb_lane_align : byte-lane select, write-data placement and read-data
//                 extraction for byte/half/word accesses on a 32-bit bus.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module wb_lane_align
  import wb_master_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata_in,
  input  logic [31:0] rdata_in,
  output logic [3:0]  sel,
  output logic [31:0] wdata_out,
  output logic [31:0] rdata_out
);

  logic [4:0]  w_shamt;
  logic [31:0] w_rshift;

  assign w_shamt   = {offset, 3'b000};
  assign wdata_out = wdata_in << w_shamt;
  assign w_rshift  = rdata_in >> w_shamt;

  always_comb begin
    sel       = 4'h0;
    rdata_out = 32'h0;
    case (size)
      SZ_BYTE: begin
        sel       = 4'b0001 << offset;
        rdata_out = {24'h0, w_rshift[7:0]};
      end
      SZ_HALF: begin
        sel       = 4'b0011 << offset;
        rdata_out = {16'h0, w_rshift[15:0]};
      end
      SZ_WORD: begin
        sel       = 4'hF;
        rdata_out = w_rshift;
      end
      default: begin
        sel       = 4'h0;
        rdata_out = 32'h0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/wb_master_if.sv
// ============================================================================
// wb_master_if : valid/ready request/response to single Wishbone classic
//                transactions, with misalignment detection and bus timeout.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module wb_master_if
  import wb_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [1:0]  req_size_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  wb_bus_t.master     wb_bus
);

  state_e r_state, w_next;

  logic             r_we;
  logic [1:0]       r_size;
  logic [1:0]       r_off;
  logic             r_cyc;
  logic             r_stb;
  logic             r_wb_we;
  logic [31:0]      r_adr;
  logic [31:0]      r_dat;
  logic [3:0]       r_sel;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rsp_err;
  logic [31:0]      r_rsp_rdata;

  logic        w_accept;
  logic        w_misal;
  logic        w_resp;
  logic        w_timeout;
  logic [1:0]  w_al_size;
  logic [1:0]  w_al_off;
  logic [3:0]  w_sel;
  logic [31:0] w_wdata_sh;
  logic [31:0] w_rdata_ex;

  // Lanes come from the live request while idle, from the captured request otherwise.
  assign w_al_size = (r_state == ST_IDLE) ? req_size_i      : r_size;
  assign w_al_off  = (r_state == ST_IDLE) ? req_addr_i[1:0] : r_off;

  wb_lane_align u_align (
    .size      (w_al_size),
    .offset    (w_al_off),
    .wdata_in  (req_wdata_i),
    .rdata_in  (wb_bus.wb_dat_sm),
    .sel       (w_sel),
    .wdata_out (w_wdata_sh),
    .rdata_out (w_rdata_ex)
  );

  assign w_accept  = req_valid_i & req_ready_o;
  assign w_misal   = is_misaligned(req_size_i, req_addr_i[1:0]);
  assign w_resp    = wb_bus.wb_ack | wb_bus.wb_err;
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = w_misal ? ST_RESP : ST_BUS;
      ST_BUS:  if (w_resp || w_timeout) w_next = ST_RESP;
      ST_RESP: if (rsp_ready_i) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = (r_state == ST_IDLE) & ~rst_i;
    rsp_valid_o = (r_state == ST_RESP);
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_we        <= 1'b0;
      r_size      <= 2'b00;
      r_off       <= 2'b00;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_wb_we     <= 1'b0;
      r_adr       <= 32'h0;
      r_dat       <= 32'h0;
      r_sel       <= 4'h0;
      r_cnt       <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 32'h0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_we        <= req_we_i;
            r_size      <= req_size_i;
            r_off       <= req_addr_i[1:0];
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= w_misal;
            if (!w_misal) begin
              r_cyc   <= 1'b1;
              r_stb   <= 1'b1;
              r_wb_we <= req_we_i;
              r_adr   <= {req_addr_i[31:2], 2'b00};
              r_dat   <= req_we_i ? w_wdata_sh : 32'h0;
              r_sel   <= w_sel;
              r_cnt   <= '0;
            end
          end
        end
        ST_BUS: begin
          if (w_resp || w_timeout) begin
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_wb_we     <= 1'b0;
            r_adr       <= 32'h0;
            r_dat       <= 32'h0;
            r_sel       <= 4'h0;
            // Anything other than a clean ack (err, or timeout) is an error.
            r_rsp_err   <= wb_bus.wb_err | ~wb_bus.wb_ack;
            r_rsp_rdata <= (wb_bus.wb_ack & ~wb_bus.wb_err & ~r_we) ? w_rdata_ex : 32'h0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'h0;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_rdata_o      = r_rsp_rdata;
  assign rsp_err_o        = r_rsp_err;
  assign wb_bus.wb_cyc    = r_cyc;
  assign wb_bus.wb_stb    = r_stb;
  assign wb_bus.wb_we     = r_wb_we;
  assign wb_bus.wb_adr    = r_adr;
  assign wb_bus.wb_dat_ms = r_dat;
  assign wb_bus.sel       = r_sel;

endmodule

`default_nettype wire
